// File: rtl/pingpong_frame_buffer.sv
// Double-banked frame capture buffer: one bank fills from the sample stream while
// the other presents a completed frame to the reader by address.
//
// bank state | meaning
// EMPTY      | free, no samples held
// FILLING    | write side storing samples of an open frame
// FULL       | frame closed, waiting to be presented
// READING    | frame presented to the reader (frame_valid)
module pingpong_frame_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  output logic                         frame_valid,
  output logic [$clog2(DEPTH):0]       frame_len,
  output logic                         frame_trunc,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  input  logic                         frame_release,
  output logic [15:0]                  drop_cnt
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_READING
  } bank_st_t;

  bank_st_t            bank_st [2];
  logic                wr_bank;
  logic                rd_bank;
  logic                discard;
  logic [ADDR_W-1:0]   wr_idx;
  logic [ADDR_W:0]     len_q [2];
  logic                trunc_q [2];
  logic [15:0]         drop_q;
  logic [DATA_W-1:0]   mem [2*DEPTH];

  logic wr_open;
  logic wr_en;
  logic drop;
  logic close_frm;
  logic rel;

  always_comb begin
    wr_open   = (bank_st[wr_bank] == BANK_EMPTY) || (bank_st[wr_bank] == BANK_FILLING);
    wr_en     = in_valid && !discard && wr_open;
    drop      = in_valid && !wr_en;
    close_frm = wr_en && (in_last || (wr_idx == LAST_IDX));
    rel       = frame_release && frame_valid;
  end

  assign in_ready = wr_open;
  assign drop_cnt = drop_q;

  // Sample RAM has no reset so it can map onto block memory.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_idx}] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0]  <= BANK_EMPTY;
      bank_st[1]  <= BANK_EMPTY;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
      trunc_q[0]  <= 1'b0;
      trunc_q[1]  <= 1'b0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_idx      <= '0;
      discard     <= 1'b0;
      drop_q      <= '0;
      frame_valid <= 1'b0;
      frame_len   <= '0;
      frame_trunc <= 1'b0;
      rd_data     <= '0;
    end else begin
      rd_data <= mem[{rd_bank, rd_addr}];

      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;

      // Any in_last ends the discard run that follows a truncated frame.
      if (in_valid && discard && in_last) discard <= 1'b0;

      if (wr_en) begin
        if (close_frm) begin
          bank_st[wr_bank] <= BANK_FULL;
          len_q[wr_bank]   <= {1'b0, wr_idx} + (ADDR_W+1)'(1);
          trunc_q[wr_bank] <= !in_last;
          wr_bank          <= ~wr_bank;
          wr_idx           <= '0;
          discard          <= !in_last;
        end else begin
          bank_st[wr_bank] <= BANK_FILLING;
          wr_idx           <= wr_idx + 1'b1;
        end
      end

      // The write side only touches EMPTY/FILLING banks and the read side only
      // FULL/READING ones, so both updates can land in the same cycle.
      if (rel) begin
        bank_st[rd_bank] <= BANK_EMPTY;
        rd_bank          <= ~rd_bank;
        frame_valid      <= 1'b0;
      end else if (!frame_valid && (bank_st[rd_bank] == BANK_FULL)) begin
        bank_st[rd_bank] <= BANK_READING;
        frame_valid      <= 1'b1;
        frame_len        <= len_q[rd_bank];
        frame_trunc      <= trunc_q[rd_bank];
      end
    end
  end

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Bench for pingpong_frame_buffer: directed scenarios plus random traffic checked
// against a queue-of-frames reference model.
module tb_pingpong_frame_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_last;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        frame_valid;
  logic [8:0]  frame_len;
  logic        frame_trunc;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        frame_release;
  logic [15:0] drop_cnt;

  pingpong_frame_buffer #(.DATA_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(in_ready), .frame_valid(frame_valid),
    .frame_len(frame_len), .frame_trunc(frame_trunc), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_release(frame_release), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: completed frames waiting or presented, in arrival order.
  logic [7:0] mdata [4][256];
  int         fr_len [4];
  bit         fr_trunc [4];
  int         pq[$];
  int         next_id;
  int         part_len;
  bit         m_discard;
  bit         presented;
  int         mdrop;
  bit         exp_rd_ok;
  logic [7:0] exp_rd;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    pq.delete();
    next_id   = 0;
    part_len  = 0;
    m_discard = 0;
    presented = 0;
    mdrop     = 0;
    exp_rd_ok = 0;
  endtask

  task automatic model_edge(input bit v, input bit l, input logic [7:0] d, input bit rel,
                            input int addr);
    bit do_rel;
    bit do_pres;
    bit full_pre;
    exp_rd_ok = presented && (addr < fr_len[pq[0] % 4]);
    if (exp_rd_ok) exp_rd = mdata[pq[0] % 4][addr];
    do_rel   = rel && presented;
    do_pres  = !presented && (pq.size() > 0);
    full_pre = (pq.size() == 2);
    if (v) begin
      if (m_discard) begin
        mdrop++;
        if (l) m_discard = 0;
      end else if (full_pre) begin
        mdrop++;
      end else begin
        mdata[next_id % 4][part_len] = d;
        part_len++;
        if (l || part_len == 256) begin
          fr_len[next_id % 4]   = part_len;
          fr_trunc[next_id % 4] = !l;
          pq.push_back(next_id);
          next_id++;
          part_len  = 0;
          m_discard = !l;
        end
      end
    end
    if (mdrop > 65535) mdrop = 65535;
    if (do_rel) begin
      void'(pq.pop_front());
      presented = 0;
    end else if (do_pres) begin
      presented = 1;
    end
  endtask

  task automatic check_all();
    check("frame_valid", frame_valid, presented);
    check("in_ready", in_ready, pq.size() < 2);
    check("drop_cnt", drop_cnt, mdrop);
    if (presented) begin
      check("frame_len", frame_len, fr_len[pq[0] % 4]);
      check("frame_trunc", frame_trunc, fr_trunc[pq[0] % 4]);
    end
    if (exp_rd_ok) check("rd_data", rd_data, exp_rd);
  endtask

  task automatic cycle(input bit v, input bit l, input logic [7:0] d, input bit rel, input int addr);
    in_valid = v; in_last = l; in_data = d; frame_release = rel; rd_addr = addr[7:0];
    @(posedge clk);
    model_edge(v, l, d, rel, addr);
    @(negedge clk);
    in_valid = 0; in_last = 0; frame_release = 0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic send_frame(input int n, input int base);
    for (int i = 0; i < n; i++) cycle(1, i == n - 1, 8'(base + i), 0, 0);
  endtask

  initial begin
    in_valid = 0; in_last = 0; in_data = 0; frame_release = 0; rd_addr = 0;
    rst_n = 0;
    model_reset();
    #12;
    check("rst_frame_valid", frame_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_len", frame_len, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    do_reset();

    // 10-sample frame, then address readback
    send_frame(10, 0);
    idle(1);
    check("t1_valid", frame_valid, 1);
    check("t1_len", frame_len, 10);
    check("t1_trunc", frame_trunc, 0);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 8'h00, 0, k);
      check("t1_rd", rd_data, k);
    end

    // 300 samples, in_last on the 300th: truncated at 256, 44 discarded
    do_reset();
    for (int i = 0; i < 300; i++) cycle(1, i == 299, 8'(i), 0, 0);
    idle(1);
    check("t2_len", frame_len, 256);
    check("t2_trunc", frame_trunc, 1);
    check("t2_drop", drop_cnt, 44);

    // three frames without release: third dropped, then in-order delivery
    do_reset();
    send_frame(4, 16);
    send_frame(4, 32);
    send_frame(4, 48);
    check("t3_drop", drop_cnt, 4);
    check("t3_ready", in_ready, 0);
    cycle(0, 0, 8'h00, 0, 1);
    check("t3_first", rd_data, 17);
    cycle(0, 0, 8'h00, 1, 0);
    check("t3_gap", frame_valid, 0);
    idle(1);
    check("t3_second_valid", frame_valid, 1);
    cycle(0, 0, 8'h00, 0, 2);
    check("t3_second", rd_data, 34);
    cycle(0, 0, 8'h00, 1, 0);
    idle(2);
    check("t3_empty", frame_valid, 0);
    check("t3_ready_again", in_ready, 1);

    // release in the same cycle the other bank closes
    do_reset();
    send_frame(3, 64);
    idle(1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'(80 + i), 0, 0);
    cycle(1, 1, 8'd84, 1, 0);
    check("t4_idle", frame_valid, 0);
    idle(1);
    check("t4_valid", frame_valid, 1);
    check("t4_len", frame_len, 5);

    // async reset mid-frame with a frame presented
    do_reset();
    send_frame(4, 96);
    idle(1);
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(110 + i), 0, 0);
    cycle(0, 0, 8'h00, 0, 1);
    #2 rst_n = 0;
    #1;
    model_reset();
    check("t5_valid", frame_valid, 0);
    check("t5_len", frame_len, 0);
    check("t5_trunc", frame_trunc, 0);
    check("t5_rd", rd_data, 0);
    check("t5_ready", in_ready, 1);
    check("t5_drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    send_frame(3, 200);
    idle(1);
    check("t5_len_new", frame_len, 3);
    cycle(0, 0, 8'h00, 0, 0);
    check("t5_rd_new", rd_data, 200);

    // saturation of the drop counter
    do_reset();
    send_frame(2, 1);
    send_frame(2, 5);
    idle(1);
    force dut.drop_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.drop_q;
    mdrop = 65534;
    check("t6_preset", drop_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) cycle(1, 0, 8'(i), 0, 0);
    check("t6_sat", drop_cnt, 16'hFFFF);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int lmod;
      int addr;
      bit rel;
      lmod = (i < 2000) ? 8 : 400;
      rel  = presented && ($urandom % 8 == 0);
      addr = presented ? int'($urandom % fr_len[pq[0] % 4]) : int'($urandom % 256);
      cycle(($urandom % 10) < 7, ($urandom % lmod) == 0, 8'($urandom), rel, addr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
